// File: rtl/clock_ui_ctrl.sv
// Front-panel controller for the digital clock: button debounce and auto-repeat,
// mode/select/enable state, and the alarm/timer ringing FSM with snooze and tone.
module clock_ui_ctrl #(
  parameter int CLK_HZ          = 100000000,
  parameter int NUM_ALARMS      = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TONE_HZ         = 1500,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int RING_TIMEOUT_S  = 60,
  parameter int SNOOZE_S        = 300,
  localparam int MW             = $clog2(NUM_ALARMS + 2)
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic                  btn_c,
  input  logic                  btn_u,
  input  logic                  btn_l,
  input  logic                  btn_r,
  input  logic                  btn_d,
  input  logic [NUM_ALARMS-1:0] alarm_hit,
  input  logic                  timer_done,
  output logic [MW-1:0]         mode,
  output logic [1:0]            select,
  output logic                  inc_pulse,
  output logic [NUM_ALARMS-1:0] alarm_enable,
  output logic                  timer_enable,
  output logic                  ringing,
  output logic [MW-1:0]         ring_src,
  output logic                  aud_pwm
);
  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW   = $clog2(REPEAT_DELAY + 1);
  localparam int CW   = $clog2(CLK_HZ + 1);
  localparam int TW   = $clog2(HALF + 1);
  localparam int SW   = $clog2(((RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S) + 1);
  localparam int BC = 0, BU = 1, BL = 2, BR = 3, BD = 4;
  localparam logic [MW-1:0] SRC_TIMER = MW'(1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNOOZE = 2'd2} state_t;
  state_t state_r, state_next;

  logic [4:0] raw_s, sync1_r, sync2_r, db_r, db_d_r, press_s;
  logic [DW-1:0] db_cnt_r [5];
  logic [RW-1:0] rep_cnt_r;
  logic rep_fire_s;
  logic [CW-1:0] cyc_cnt_r;
  logic [SW-1:0] sec_cnt_r;
  logic [TW-1:0] tone_cnt_r;
  logic tick_s, ring_timeout_s, snooze_done_s, tone_wrap_s;
  logic [NUM_ALARMS-1:0] alarm_prev_r, alarm_rise_s, cur_mask_s, alarm_en_r, alarm_en_next;
  logic timer_prev_r, timer_rise_s, trig_s, is_alarm_mode_s;
  logic [MW-1:0] trig_src_s, mode_r, mode_next, ring_src_r, ring_src_next;
  logic [1:0] select_r, select_next;
  logic timer_en_r, timer_en_next, inc_r, inc_next, ringing_r, aud_r;

  assign raw_s   = {btn_d, btn_r, btn_l, btn_u, btn_c};
  assign press_s = db_r & ~db_d_r;

  // Synchronise each button and flip its level after a run of differing samples.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync1_r <= 5'd0;
      sync2_r <= 5'd0;
      db_r    <= 5'd0;
      db_d_r  <= 5'd0;
      for (int i = 0; i < 5; i++) db_cnt_r[i] <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      db_d_r  <= db_r;
      for (int i = 0; i < 5; i++) begin
        if (sync2_r[i] != db_r[i]) begin
          if (db_cnt_r[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_r[i]     <= sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Hold time on btn_u; after a repeat fires, rewind so the next lands one period later.
  assign rep_fire_s = db_r[BU] && !press_s[BU] && (rep_cnt_r == RW'(REPEAT_DELAY));
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset)              rep_cnt_r <= '0;
    else if (!db_r[BU])     rep_cnt_r <= '0;
    else if (press_s[BU])   rep_cnt_r <= RW'(1);
    else if (rep_fire_s)    rep_cnt_r <= RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    else                    rep_cnt_r <= rep_cnt_r + RW'(1);
  end

  assign alarm_rise_s   = alarm_hit & ~alarm_prev_r & alarm_en_r;
  assign timer_rise_s   = timer_done & ~timer_prev_r & timer_en_r;
  assign trig_s         = (|alarm_rise_s) | timer_rise_s;
  assign tick_s         = (cyc_cnt_r == CW'(CLK_HZ - 1));
  assign ring_timeout_s = tick_s && (sec_cnt_r == SW'(RING_TIMEOUT_S - 1));
  assign snooze_done_s  = tick_s && (sec_cnt_r == SW'(SNOOZE_S - 1));
  assign tone_wrap_s    = (tone_cnt_r == TW'(HALF - 1));
  assign is_alarm_mode_s = |cur_mask_s;

  // Current-alarm mask and trigger source: lowest alarm index beats the timer.
  always_comb begin
    cur_mask_s = '0;
    trig_src_s = SRC_TIMER;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      cur_mask_s[k] = (mode_r == MW'(k + 2));
      trig_src_s    = alarm_rise_s[k] ? MW'(k + 2) : trig_src_s;
    end
  end

  // Ring FSM next state together with the panel state it owns.
  always_comb begin
    state_next    = state_r;
    mode_next     = mode_r;
    select_next   = select_r;
    timer_en_next = timer_en_r;
    alarm_en_next = alarm_en_r;
    ring_src_next = ring_src_r;
    inc_next      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_next    = ST_RING;
          ring_src_next = trig_src_s;
          mode_next     = trig_src_s;
          select_next   = 2'd0;
        end else begin
          inc_next = (press_s[BU] | rep_fire_s) & (select_r != 2'd0);
          if (press_s[BC]) begin
            if (mode_r == SRC_TIMER) timer_en_next = ~timer_en_r;
            else                     alarm_en_next = alarm_en_r ^ cur_mask_s;
          end else begin
            alarm_en_next = alarm_en_r;
          end
          if (press_s[BL]) alarm_en_next = alarm_en_next ^ (is_alarm_mode_s ? cur_mask_s : {NUM_ALARMS{1'b1}});
          else             alarm_en_next = alarm_en_next;
          if (press_s[BD]) select_next = select_r + 2'd1;
          else             select_next = select_r;
          // Mode advance also sets select, so it overrides a same-cycle btn_d.
          if (press_s[BR]) begin
            mode_next   = (mode_r == MW'(NUM_ALARMS + 1)) ? {MW{1'b0}} : mode_r + MW'(1);
            select_next = (mode_next == {MW{1'b0}}) ? 2'd0 : 2'd1;
            if (mode_r == SRC_TIMER) timer_en_next = 1'b0;
            else                     timer_en_next = timer_en_next;
          end else begin
            mode_next = mode_r;
          end
        end
      end
      ST_RING: begin
        if (press_s[BC] || ring_timeout_s) begin
          state_next    = ST_IDLE;
          timer_en_next = (ring_src_r == SRC_TIMER) ? 1'b0 : timer_en_r;
        end else if (press_s[BL] && (ring_src_r != SRC_TIMER)) begin
          state_next = ST_SNOOZE;
        end else begin
          state_next = ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (press_s[BC])        state_next = ST_IDLE;
        else if (snooze_done_s) state_next = ST_RING;
        else                    state_next = ST_SNOOZE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      mode_r     <= '0;
      select_r   <= 2'd0;
      timer_en_r <= 1'b0;
      alarm_en_r <= '0;
      ring_src_r <= '0;
      inc_r      <= 1'b0;
      ringing_r  <= 1'b0;
    end else begin
      state_r    <= state_next;
      mode_r     <= mode_next;
      select_r   <= select_next;
      timer_en_r <= timer_en_next;
      alarm_en_r <= alarm_en_next;
      ring_src_r <= ring_src_next;
      inc_r      <= inc_next;
      ringing_r  <= (state_next != ST_IDLE);
    end
  end

  // Edge history, seconds/tone timebase (restarted on every state entry) and tone.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      alarm_prev_r <= '0;
      timer_prev_r <= 1'b0;
      cyc_cnt_r    <= '0;
      sec_cnt_r    <= '0;
      tone_cnt_r   <= '0;
      aud_r        <= 1'b0;
    end else begin
      alarm_prev_r <= alarm_hit;
      timer_prev_r <= timer_done;
      if ((state_next != state_r) || (state_r == ST_IDLE)) begin
        cyc_cnt_r  <= '0;
        sec_cnt_r  <= '0;
        tone_cnt_r <= '0;
      end else begin
        cyc_cnt_r  <= tick_s ? '0 : cyc_cnt_r + CW'(1);
        sec_cnt_r  <= tick_s ? sec_cnt_r + SW'(1) : sec_cnt_r;
        tone_cnt_r <= tone_wrap_s ? '0 : tone_cnt_r + TW'(1);
      end
      if ((state_r == ST_RING) && (state_next == ST_RING)) aud_r <= tone_wrap_s ? ~aud_r : aud_r;
      else                                                 aud_r <= 1'b0;
    end
  end

  assign mode         = mode_r;
  assign select       = select_r;
  assign inc_pulse    = inc_r;
  assign alarm_enable = alarm_en_r;
  assign timer_enable = timer_en_r;
  assign ringing      = ringing_r;
  assign ring_src     = ring_src_r;
  assign aud_pwm      = aud_r;
endmodule

// File: tb/tb_clock_ui_ctrl.sv
// Directed bench for clock_ui_ctrl using small timing parameters
// (HALF=5, 1 s = 1000 cycles, 4-cycle debounce).
module tb_clock_ui_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] btns;
  logic [1:0] alarm_hit;
  logic       timer_done;
  logic [1:0] mode, select, alarm_enable, ring_src;
  logic       inc_pulse, timer_enable, ringing, aud_pwm;
  logic [11:0] all_o;

  int n_tests = 0;
  int n_fail  = 0;
  int first, found, found2;
  logic [63:0] obs, exp_mask;

  typedef struct {
    int         btn;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       te;
    logic [1:0] ae;
  } vec_t;
  vec_t tbl [14];

  clock_ui_ctrl #(
    .CLK_HZ(1000), .NUM_ALARMS(2), .DEBOUNCE_CYCLES(4), .TONE_HZ(100),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .RING_TIMEOUT_S(3), .SNOOZE_S(2)
  ) dut (
    .CLK100MHZ(clk), .reset(reset),
    .btn_c(btns[0]), .btn_u(btns[1]), .btn_l(btns[2]), .btn_r(btns[3]), .btn_d(btns[4]),
    .alarm_hit(alarm_hit), .timer_done(timer_done),
    .mode(mode), .select(select), .inc_pulse(inc_pulse), .alarm_enable(alarm_enable),
    .timer_enable(timer_enable), .ringing(ringing), .ring_src(ring_src), .aud_pwm(aud_pwm)
  );

  assign all_o = {mode, select, inc_pulse, alarm_enable, timer_enable, ringing, ring_src, aud_pwm};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input int b);
    btns[b] = 1'b1;
    cycles(10);
    btns[b] = 1'b0;
    cycles(10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Button indices: 0=C 1=U 2=L 3=R 4=D. Starting point: mode=1 sel=1 te=0 ae=00.
    tbl[0]  = '{0, 2'd1, 2'd1, 1'b1, 2'b00};
    tbl[1]  = '{4, 2'd1, 2'd2, 1'b1, 2'b00};
    tbl[2]  = '{4, 2'd1, 2'd3, 1'b1, 2'b00};
    tbl[3]  = '{4, 2'd1, 2'd0, 1'b1, 2'b00};
    tbl[4]  = '{3, 2'd2, 2'd1, 1'b0, 2'b00};
    tbl[5]  = '{0, 2'd2, 2'd1, 1'b0, 2'b01};
    tbl[6]  = '{2, 2'd2, 2'd1, 1'b0, 2'b00};
    tbl[7]  = '{3, 2'd3, 2'd1, 1'b0, 2'b00};
    tbl[8]  = '{0, 2'd3, 2'd1, 1'b0, 2'b10};
    tbl[9]  = '{3, 2'd0, 2'd0, 1'b0, 2'b10};
    tbl[10] = '{2, 2'd0, 2'd0, 1'b0, 2'b01};
    tbl[11] = '{0, 2'd0, 2'd0, 1'b0, 2'b01};
    tbl[12] = '{4, 2'd0, 2'd1, 1'b0, 2'b01};
    tbl[13] = '{3, 2'd1, 2'd1, 1'b0, 2'b01};

    reset = 1'b1; btns = 5'd0; alarm_hit = 2'b00; timer_done = 1'b0;
    cycles(3);
    check("reset_outputs", 64'(all_o), 64'(0));
    reset = 1'b0;
    cycles(2);

    // Short glitch must not pass the debouncer.
    btns[3] = 1'b1; cycles(3); btns[3] = 1'b0; cycles(10);
    check("glitch_mode", 64'(mode), 64'(0));

    // Clean press: mode changes on the 7th edge after the input edge.
    btns[3] = 1'b1;
    cycles(6);
    check("press_before_7", 64'({mode, select}), 64'(0));
    cycles(1);
    check("press_at_7", 64'({mode, select}), 64'({2'd1, 2'd1}));
    cycles(3); btns[3] = 1'b0; cycles(10);

    for (int i = 0; i < 14; i++) begin
      press_btn(tbl[i].btn);
      check($sformatf("table_%0d", i), 64'({mode, select, timer_enable, alarm_enable}),
            64'({tbl[i].mode, tbl[i].sel, tbl[i].te, tbl[i].ae}));
    end

    // Auto-repeat with select=SEC: pulses at 0, 20, 25, 30, 35 relative to the first.
    first = -1;
    btns[1] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (inc_pulse) begin first = i; break; end
    end
    check("rep_first_latency", 64'(first), 64'(7));
    obs = 64'd0;
    obs[0] = (first > 0);
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      obs[k] = inc_pulse;
      if (k == 31) btns[1] = 1'b0;
    end
    exp_mask = 64'd0;
    exp_mask[0] = 1'b1; exp_mask[20] = 1'b1; exp_mask[25] = 1'b1;
    exp_mask[30] = 1'b1; exp_mask[35] = 1'b1;
    check("rep_pattern", obs, exp_mask);
    cycles(10);

    // select back to NONE, then hold btn_u: no pulses at all.
    press_btn(4); press_btn(4); press_btn(4);
    obs = 64'd0;
    btns[1] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      obs[k] = inc_pulse;
      if (k == 40) btns[1] = 1'b0;
    end
    check("rep_none", obs, 64'd0);
    cycles(5);

    // Alarm ring: enables 10, both hits rise -> alarm 1 (code 3) rings.
    press_btn(2);
    check("ae_before_ring", 64'({mode, select, alarm_enable}), 64'({2'd1, 2'd0, 2'b10}));
    alarm_hit = 2'b11;
    @(negedge clk);
    check("ring_entry", 64'(all_o),
          64'({2'd3, 2'd0, 1'b0, 2'b10, 1'b0, 1'b1, 2'd3, 1'b0}));
    obs = 64'd0; exp_mask = 64'd0;
    obs[0] = aud_pwm;
    for (int j = 1; j < 30; j++) begin
      @(negedge clk);
      obs[j] = aud_pwm;
    end
    for (int j = 0; j < 30; j++) exp_mask[j] = ((j / 5) % 2) == 1;
    check("aud_pattern", obs, exp_mask);

    // Snooze, resume after 2000 cycles, then auto-dismiss 3000 cycles later.
    found = -1; found2 = -1;
    btns[2] = 1'b1;
    for (int t = 1; t <= 3000; t++) begin
      @(negedge clk);
      if (t == 10) btns[2] = 1'b0;
      if (t == 20) check("snooze_quiet", 64'({ringing, aud_pwm}), 64'({1'b1, 1'b0}));
      if (t > 20 && aud_pwm) begin found = t; break; end
    end
    check("snooze_resume", 64'(found), 64'(2012));
    for (int t = 2013; t <= 6000; t++) begin
      @(negedge clk);
      if (!ringing) begin found2 = t; break; end
    end
    check("ring_timeout", 64'(found2), 64'(5007));
    check("timeout_quiet", 64'({ringing, aud_pwm, mode}), 64'({1'b0, 1'b0, 2'd3}));
    cycles(5);
    check("no_retrigger", 64'(ringing), 64'(0));
    alarm_hit = 2'b00;
    cycles(3);

    // Timer ring: btn_l ignored, btn_c dismisses and clears timer_enable.
    press_btn(3); press_btn(3); press_btn(0);
    check("timer_armed", 64'({mode, timer_enable}), 64'({2'd1, 1'b1}));
    timer_done = 1'b1;
    @(negedge clk);
    check("timer_entry", 64'({ringing, ring_src, mode, select}), 64'({1'b1, 2'd1, 2'd1, 2'd0}));
    press_btn(2);
    check("timer_l_ignored", 64'(ringing), 64'(1));
    press_btn(0);
    check("timer_dismiss", 64'({ringing, timer_enable, aud_pwm}), 64'(0));
    timer_done = 1'b0;
    cycles(3);

    // Simultaneous alarm0 + timer, both enabled: alarm0 (code 2) wins.
    press_btn(3); press_btn(0); press_btn(3); press_btn(3); press_btn(3); press_btn(0);
    check("simul_setup", 64'({mode, timer_enable, alarm_enable}), 64'({2'd1, 1'b1, 2'b11}));
    alarm_hit = 2'b01; timer_done = 1'b1;
    @(negedge clk);
    check("simul_src", 64'({ringing, ring_src, mode}), 64'({1'b1, 2'd2, 2'd2}));
    alarm_hit = 2'b11;
    cycles(3);
    check("second_edge_dropped", 64'({ringing, ring_src, mode}), 64'({1'b1, 2'd2, 2'd2}));
    press_btn(0);
    check("alarm_dismiss_keeps_te", 64'({ringing, timer_enable}), 64'({1'b0, 1'b1}));
    alarm_hit = 2'b00; timer_done = 1'b0;
    cycles(3);

    // Reset in the middle of a ring clears everything asynchronously.
    alarm_hit = 2'b10;
    @(negedge clk);
    check("pre_reset_ring", 64'({ringing, ring_src}), 64'({1'b1, 2'd3}));
    cycles(7);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", 64'(all_o), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    cycles(2);
    check("after_reset", 64'(all_o), 64'(0));
    press_btn(0);
    check("post_reset_btn_c", 64'(all_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clock_ui_ctrl.md
Name: clock_ui_ctrl

Overview:
Parametrised front-panel controller for the digital clock. It debounces the five push buttons and generates auto-repeat increment pulses. It runs the mode/select/enable state for one countdown timer and NUM_ALARMS alarm channels, and owns a ringing FSM with snooze, timeout and a square-wave tone on aud_pwm. It sits between the board pins and the clock core, which supplies the alarm_hit/timer_done levels.

Parameters:
CLK_HZ, 100000000, CLK100MHZ frequency; base for the 1 s tick and the tone divider
NUM_ALARMS, 2, number of alarm channels (>=1)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a debounced level changes
TONE_HZ, 1500, aud_pwm frequency; half-period HALF = CLK_HZ/(2*TONE_HZ), integer-truncated
REPEAT_DELAY, 50000000, cycles btn_u must be held before auto-repeat starts
REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses
RING_TIMEOUT_S, 60, seconds of RING before automatic dismiss
SNOOZE_S, 300, snooze length in seconds

Ports:
CLK100MHZ  in  1  system clock
reset  in  1  asynchronous, active-high
btn_c, btn_u, btn_l, btn_r, btn_d  in  1 each  raw asynchronous buttons
alarm_hit  in  NUM_ALARMS  level from clock core; high while alarm k time matches
timer_done  in  1  level from clock core; high while timer reads zero
mode  out  MW=$clog2(NUM_ALARMS+2)  0=CLOCK, 1=TIMER, 2+k=ALARM k
select  out  2  0=NONE, 1=SEC, 2=MIN, 3=HOUR
inc_pulse  out  1  one-cycle increment strobe to the clock core
alarm_enable  out  NUM_ALARMS  per-channel arm bits
timer_enable  out  1  timer run bit
ringing  out  1  high in RING or SNOOZE
ring_src  out  MW  mode code of the ringing source
aud_pwm  out  1  tone output

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0. The reset is asynchronous, active-high; CLK100MHZ is the clock.
- Debounce, per button:
  - 2-flop synchroniser feeds a counter.
  - Debounced level flips after DEBOUNCE_CYCLES consecutive cycles where the synchronised value differs from it.
  - Press event = one-cycle pulse on the debounced 0->1 transition.
- inc_pulse, only when select!=NONE and FSM=IDLE:
  - Fires on the btn_u press event.
  - If btn_u is held REPEAT_DELAY cycles after the press, fires again, then every REPEAT_PERIOD cycles while held.
  - Releasing btn_u clears the repeat counter.
- btn_r press (IDLE only): mode advances CLOCK->TIMER->ALARM0->...->ALARM(N-1)->CLOCK.
  - select <= SEC, or NONE when the new mode is CLOCK.
  - Leaving TIMER clears timer_enable.
- btn_d press (IDLE only): select cycles NONE->SEC->MIN->HOUR->NONE. If pressed in the same cycle as btn_r, btn_r's select assignment wins.
- btn_c press in IDLE:
  - TIMER mode: toggle timer_enable.
  - ALARM k: toggle alarm_enable[k].
  - CLOCK mode: no effect.
- btn_l press in IDLE: toggle alarm_enable for the current alarm mode; otherwise toggle all alarm_enable bits together.
- Ring FSM, IDLE->RING:
  - Trigger is a rising edge (registered previous value) of alarm_hit[k] with alarm_enable[k]=1, or a rising edge of timer_done with timer_enable=1.
  - Lowest alarm index wins; alarms beat the timer in the same cycle.
  - On entry: ring_src <= source code, mode <= ring_src, select <= NONE, tone counter and seconds counter cleared.
- RING:
  - aud_pwm toggles every HALF cycles; first toggle HALF cycles after entry.
  - btn_c = dismiss -> IDLE. A timer source also clears timer_enable.
  - btn_l on an alarm source = snooze -> SNOOZE. btn_l on a timer source is ignored.
  - RING_TIMEOUT_S elapsed -> IDLE, behaving as a dismiss.
  - btn_r, btn_d and btn_u are ignored.
- SNOOZE:
  - aud_pwm=0.
  - After SNOOZE_S seconds -> RING, with the same ring_src.
  - btn_c -> IDLE (cancel).
- New triggers arriving in RING or SNOOZE are dropped, not queued.
- aud_pwm is 0 whenever the FSM is not in RING; it is forced to 0 on leaving RING.
- Seconds tick: internal counter wraps at CLK_HZ-1. It is cleared on every FSM state entry, so durations are exact to ±0 cycles from entry.
- Reset mid-operation: immediate return to reset values, including mid-ring and mid-debounce.

Test Plan:
Use CLK_HZ=1000, DEBOUNCE_CYCLES=4, TONE_HZ=100 (HALF=5), REPEAT_DELAY=20, REPEAT_PERIOD=5, RING_TIMEOUT_S=3, SNOOZE_S=2, NUM_ALARMS=2.
- Debounce: btn_r glitch of 3 cycles -> mode stays 0. Clean press of 10 cycles -> mode=1, select=1 exactly 2+4+1 cycles after the edge. Four more presses -> mode sequence 2, 3, 0, then select=0.
- Auto-repeat: select=SEC, btn_u held 40 cycles after debounce -> inc_pulse at t=0, 20, 25, 30, 35. With select=NONE -> no pulses.
- Alarm ring and snooze: alarm_enable=2'b10, raise alarm_hit=2'b11 -> ringing=1, ring_src=3, mode=3, aud_pwm period 10 cycles. btn_l -> aud_pwm=0. Ringing resumes after 2000 cycles; no btn -> IDLE 3000 cycles later.
- Timer dismiss: mode TIMER, timer_enable=1, timer_done rises -> ring_src=1. btn_l ignored; btn_c -> IDLE, timer_enable=0, aud_pwm=0.
- Simultaneous: alarm_hit[0] and timer_done rise in the same cycle, both enabled -> ring_src=2. A second alarm_hit edge during RING is ignored.
- Reset mid-RING: assert reset for 1 cycle -> all outputs 0 asynchronously. Subsequent btn_c press -> no ringing.
